// File: rtl/tone_vote_detector.sv
// Goertzel bin classifier with per-bin dominance ratio, sliding-window majority vote and
// a one-shot hit event with hold-off. Pipeline: capture -> classify -> window -> vote -> hit.
module tone_vote_detector #(
    parameter int NUM_BINS    = 4,
    parameter int PWR_WIDTH   = 64,
    parameter int SHIFT_W     = 4,
    parameter int WIN_DEPTH   = 16,
    parameter int VOTE_THRESH = 8,
    parameter int HOLDOFF     = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_BINS-1:0]             advance,
    input  logic [NUM_BINS*PWR_WIDTH-1:0]   power,
    input  logic [NUM_BINS*SHIFT_W-1:0]     ratio_shift,
    output logic [2:0]                      result,
    output logic                            result_valid,
    output logic [2:0]                      overall_result,
    output logic                            overall_valid,
    output logic                            hit,
    output logic [2:0]                      hit_bin
);

    localparam int CNT_W = $clog2(WIN_DEPTH + 1);
    localparam int PTR_W = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;
    localparam int HO_W  = $clog2(HOLDOFF + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_REARM = 2'd2;

    // stage 0: captured powers and shifts
    logic                 s0_valid_q, s0_valid_d;
    logic [PWR_WIDTH-1:0] pwr_q   [NUM_BINS];
    logic [PWR_WIDTH-1:0] pwr_d   [NUM_BINS];
    logic [SHIFT_W-1:0]   shift_q [NUM_BINS];
    logic [SHIFT_W-1:0]   shift_d [NUM_BINS];

    // stage 1: classification
    logic [2:0]           result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic [PWR_WIDTH-1:0] scaled_s;
    logic                 beats_s;
    logic                 found_s;
    logic [2:0]           win_code_s;

    // window
    logic [2:0]           buf_q [WIN_DEPTH];
    logic [2:0]           buf_d [WIN_DEPTH];
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]     cnt_q [NUM_BINS+1];
    logic [CNT_W-1:0]     cnt_d [NUM_BINS+1];
    logic                 win_upd_q, win_upd_d;
    logic [2:0]           old_code_s;

    // vote
    logic [2:0]           overall_result_q, overall_result_d;
    logic                 overall_valid_q, overall_valid_d;
    logic                 vote_upd_q, vote_upd_d;
    logic [2:0]           winner_s;

    // hit FSM
    logic [1:0]           state_q, state_d;
    logic [HO_W-1:0]      ho_cnt_q, ho_cnt_d;
    logic                 hit_q, hit_d;
    logic [2:0]           hit_bin_q, hit_bin_d;

    // Capture powers on any advance bit, clamping negative powers to zero.
    always_comb begin
        s0_valid_d = |advance;
        for (int k = 0; k < NUM_BINS; k++) begin
            if (|advance) begin
                if (power[k*PWR_WIDTH + PWR_WIDTH - 1]) begin
                    pwr_d[k] = '0;
                end else begin
                    pwr_d[k] = power[k*PWR_WIDTH +: PWR_WIDTH];
                end
                shift_d[k] = ratio_shift[k*SHIFT_W +: SHIFT_W];
            end else begin
                pwr_d[k]   = pwr_q[k];
                shift_d[k] = shift_q[k];
            end
        end
    end

    // Stage-0 registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            for (int k = 0; k < NUM_BINS; k++) begin
                pwr_q[k]   <= '0;
                shift_q[k] <= '0;
            end
        end else begin
            s0_valid_q <= s0_valid_d;
            for (int k = 0; k < NUM_BINS; k++) begin
                pwr_q[k]   <= pwr_d[k];
                shift_q[k] <= shift_d[k];
            end
        end
    end

    // Bin k wins when its scaled power beats every other bin; lowest index takes ties.
    always_comb begin
        scaled_s   = '0;
        beats_s    = 1'b0;
        found_s    = 1'b0;
        win_code_s = 3'd0;
        for (int k = 0; k < NUM_BINS; k++) begin
            scaled_s = pwr_q[k] >> shift_q[k];
            beats_s  = 1'b1;
            for (int j = 0; j < NUM_BINS; j++) begin
                beats_s = beats_s & ((j == k) | (scaled_s > pwr_q[j]));
            end
            if (beats_s && !found_s) begin
                win_code_s = 3'(k + 1);
                found_s    = 1'b1;
            end else begin
                win_code_s = win_code_s;
                found_s    = found_s;
            end
        end
        result_d       = s0_valid_q ? win_code_s : result_q;
        result_valid_d = s0_valid_q;
    end

    // Stage-1 registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q       <= 3'd0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Window update: fill until full, then evict oldest slot at the write pointer.
    always_comb begin
        for (int i = 0; i < WIN_DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end
        for (int b = 0; b <= NUM_BINS; b++) begin
            cnt_d[b] = cnt_q[b];
        end
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        old_code_s = buf_q[ptr_q];
        win_upd_d  = result_valid_q;
        if (result_valid_q) begin
            buf_d[ptr_q] = result_q;
            ptr_d = (ptr_q == PTR_W'(WIN_DEPTH - 1)) ? {PTR_W{1'b0}} : ptr_q + 1'b1;
            if (fill_q < CNT_W'(WIN_DEPTH)) begin
                fill_d          = fill_q + 1'b1;
                cnt_d[result_q] = cnt_q[result_q] + 1'b1;
            end else if (old_code_s != result_q) begin
                cnt_d[result_q]   = cnt_q[result_q] + 1'b1;
                cnt_d[old_code_s] = cnt_q[old_code_s] - 1'b1;
            end else begin
                fill_d = fill_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Window registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            fill_q    <= '0;
            win_upd_q <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                buf_q[i] <= 3'd0;
            end
            for (int b = 0; b <= NUM_BINS; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            win_upd_q <= win_upd_d;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            for (int b = 0; b <= NUM_BINS; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Vote: lowest bin reaching the threshold, suppressed until the window is full.
    always_comb begin
        winner_s = 3'd0;
        for (int k = NUM_BINS; k >= 1; k--) begin
            if (cnt_q[k] >= CNT_W'(VOTE_THRESH)) begin
                winner_s = 3'(k);
            end else begin
                winner_s = winner_s;
            end
        end
        overall_valid_d  = (fill_q == CNT_W'(WIN_DEPTH));
        overall_result_d = overall_valid_d ? winner_s : 3'd0;
        vote_upd_d       = win_upd_q;
    end

    // Vote registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            overall_result_q <= 3'd0;
            overall_valid_q  <= 1'b0;
            vote_upd_q       <= 1'b0;
        end else begin
            overall_result_q <= overall_result_d;
            overall_valid_q  <= overall_valid_d;
            vote_upd_q       <= vote_upd_d;
        end
    end

    // Hit FSM; IDLE is only ever entered with a silent vote, so any nonzero vote there is an onset.
    always_comb begin
        state_d   = state_q;
        ho_cnt_d  = ho_cnt_q;
        hit_d     = 1'b0;
        hit_bin_d = hit_bin_q;
        case (state_q)
            ST_IDLE: begin
                if (vote_upd_q && (overall_result_q != 3'd0)) begin
                    hit_d     = 1'b1;
                    hit_bin_d = overall_result_q;
                    ho_cnt_d  = '0;
                    state_d   = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (vote_upd_q) begin
                    if (ho_cnt_q == HO_W'(HOLDOFF - 1)) begin
                        state_d = ST_REARM;
                    end else begin
                        ho_cnt_d = ho_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_REARM: begin
                if (vote_upd_q) begin
                    if (overall_result_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else if (overall_result_q != hit_bin_q) begin
                        hit_d     = 1'b1;
                        hit_bin_d = overall_result_q;
                        ho_cnt_d  = '0;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d = ST_REARM;
                    end
                end else begin
                    state_d = ST_REARM;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ho_cnt_d = '0;
            end
        endcase
    end

    // Hit FSM registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ho_cnt_q  <= '0;
            hit_q     <= 1'b0;
            hit_bin_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            ho_cnt_q  <= ho_cnt_d;
            hit_q     <= hit_d;
            hit_bin_q <= hit_bin_d;
        end
    end

    assign result         = result_q;
    assign result_valid   = result_valid_q;
    assign overall_result = overall_result_q;
    assign overall_valid  = overall_valid_q;
    assign hit            = hit_q;
    assign hit_bin        = hit_bin_q;

endmodule

// File: tb/tb_tone_vote_detector.sv
// Directed self-checking bench for tone_vote_detector (default parameters).
module tb_tone_vote_detector;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   advance;
    logic [255:0] power;
    logic [15:0]  ratio_shift;
    logic [2:0]   result;
    logic         result_valid;
    logic [2:0]   overall_result;
    logic         overall_valid;
    logic         hit;
    logic [2:0]   hit_bin;

    int checks = 0;
    int errors = 0;
    int rv_count = 0;
    int hit_count = 0;
    int dbl_hits = 0;
    logic hit_prev = 1'b0;
    logic [3:0] adv_pat = 4'b0001;
    int exp_q[$];
    int win_q[$];

    tone_vote_detector dut (
        .clk(clk), .reset(reset), .advance(advance), .power(power),
        .ratio_shift(ratio_shift), .result(result), .result_valid(result_valid),
        .overall_result(overall_result), .overall_valid(overall_valid),
        .hit(hit), .hit_bin(hit_bin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        advance = 4'b0000;
        cyc(n);
    endtask

    function automatic logic [255:0] mk_pw(input int code);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*64 +: 64] = (k + 1 == code) ? 64'd1000 : 64'd100;
        return v;
    endfunction

    // one sample for one cycle; expected classification is given by the caller
    task automatic send(input int exp_code, input logic [255:0] pw, input logic [15:0] sh);
        power       = pw;
        ratio_shift = sh;
        advance     = adv_pat;
        adv_pat     = {adv_pat[2:0], adv_pat[3]};
        exp_q.push_back(exp_code);
        win_q.push_back(exp_code);
        if (win_q.size() > 16) void'(win_q.pop_front());
        cyc(1);
    endtask

    function automatic int model_cnt(input int code);
        int n = 0;
        foreach (win_q[i]) if (win_q[i] == code) n++;
        return n;
    endfunction

    function automatic int dut_sum();
        int s = 0;
        for (int k = 0; k < 5; k++) s += int'(dut.cnt_q[k]);
        return s;
    endfunction

    // result monitor: every strobe must match the next expected classification
    always @(negedge clk) begin
        if (result_valid) begin
            rv_count++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed=%0d expected=none", result);
            end
            if (exp_q.size() != 0) chk("result_stream", 64'(result), 64'(exp_q.pop_front()));
        end
        if (hit) hit_count++;
        if (hit && hit_prev) dbl_hits++;
        hit_prev = hit;
    end

    initial begin
        logic [255:0] v;
        int base;
        reset = 1'b1; advance = 4'b0000; power = '0; ratio_shift = 16'h0000;
        cyc(5);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_ovalid", 64'(overall_valid), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_fill", 64'(dut.fill_q), 64'd0);
        reset = 1'b0;

        // 1: single sample, latency 2
        v = '0; v[63:0] = 64'd1000;
        send(1, v, 16'h3333);
        advance = 4'b0000;
        chk("t1_rv_early", 64'(result_valid), 64'd0);
        cyc(1);
        chk("t1_rv", 64'(result_valid), 64'd1);
        chk("t1_result", 64'(result), 64'd1);
        chk("t1_ovalid", 64'(overall_valid), 64'd0);
        cyc(1);
        chk("t1_rv_pulse", 64'(result_valid), 64'd0);
        chk("t1_fill", 64'(dut.fill_q), 64'd1);

        // 2: fill window with bin 1
        for (int i = 0; i < 14; i++) send(1, mk_pw(1), 16'h3333);
        idle(5);
        chk("t2_ovalid_15", 64'(overall_valid), 64'd0);
        chk("t2_fill_15", 64'(dut.fill_q), 64'd15);
        chk("t2_nohit_15", 64'(hit_count), 64'd0);
        send(1, mk_pw(1), 16'h3333);
        idle(5);
        chk("t2_ovalid", 64'(overall_valid), 64'd1);
        chk("t2_overall", 64'(overall_result), 64'd1);
        chk("t2_hits", 64'(hit_count), 64'd1);
        chk("t2_hit_bin", 64'(hit_bin), 64'd1);
        v = '0; v[63:0] = 64'd700; v[127:64] = 64'd100;
        send(0, v, 16'h3333);
        advance = 4'b0000;
        cyc(1);
        chk("t2_ratio_rv", 64'(result_valid), 64'd1);
        chk("t2_ratio_res", 64'(result), 64'd0);
        v = '0; v[63:0] = 64'hFFFF_FFFF_FFFF_EC78; v[127:64] = 64'd1000;
        send(2, v, 16'h3333);
        v = '0; v[63:0] = 64'd100; v[127:64] = 64'd101;
        send(2, v, 16'h3303);
        idle(5);
        for (int k = 0; k < 5; k++) chk("t2_cnt", 64'(dut.cnt_q[k]), 64'(model_cnt(k)));

        // 3: alternate 2/3, then drain with silence
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 2 : 3, mk_pw((i % 2 == 0) ? 2 : 3), 16'h3333);
        idle(5);
        chk("t3_cnt2", 64'(dut.cnt_q[2]), 64'd8);
        chk("t3_cnt3", 64'(dut.cnt_q[3]), 64'd8);
        chk("t3_overall", 64'(overall_result), 64'd2);
        for (int i = 0; i < 16; i++) begin
            send(0, mk_pw(0), 16'h3333);
            advance = 4'b0000;
            cyc(2);
            chk("t3_sum", 64'(dut_sum()), 64'd16);
        end
        idle(4);
        chk("t3_cnt0", 64'(dut.cnt_q[0]), 64'd16);
        chk("t3_overall_0", 64'(overall_result), 64'd0);

        // 4: back-to-back mixed codes
        base = rv_count;
        for (int i = 0; i < 40; i++) send(i % 5, mk_pw(i % 5), 16'h3333);
        idle(6);
        chk("t4_strobes", 64'(rv_count - base), 64'd40);
        chk("t4_cnt4", 64'(dut.cnt_q[4]), 64'd4);
        for (int k = 0; k < 5; k++) chk("t4_cnt", 64'(dut.cnt_q[k]), 64'(model_cnt(k)));
        chk("t4_overall", 64'(overall_result), 64'd0);

        // 5: hold-off
        reset = 1'b1;
        cyc(1);
        chk("t5_rst_hit_bin", 64'(hit_bin), 64'd0);
        chk("t5_rst_ovalid", 64'(overall_valid), 64'd0);
        chk("t5_rst_fill", 64'(dut.fill_q), 64'd0);
        cyc(1);
        reset = 1'b0;
        exp_q.delete(); win_q.delete(); hit_count = 0;
        for (int i = 0; i < 16; i++) send(1, mk_pw(1), 16'h3333);
        idle(5);
        chk("t5_hit1", 64'(hit_count), 64'd1);
        chk("t5_hit_bin1", 64'(hit_bin), 64'd1);
        chk("t5_state_hold", 64'(dut.state_q), 64'd1);
        for (int i = 0; i < 24; i++) send(4, mk_pw(4), 16'h3333);
        idle(5);
        chk("t5_overall4", 64'(overall_result), 64'd4);
        chk("t5_nohit", 64'(hit_count), 64'd1);
        chk("t5_hit_bin_held", 64'(hit_bin), 64'd1);
        for (int i = 0; i < 20; i++) send(4, mk_pw(4), 16'h3333);
        idle(5);
        chk("t5_hit2", 64'(hit_count), 64'd2);
        chk("t5_hit_bin4", 64'(hit_bin), 64'd4);
        chk("t5_no_double", 64'(dbl_hits), 64'd0);

        // 6: reset mid-window with an in-flight sample
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_q.delete(); win_q.delete();
        for (int i = 0; i < 10; i++) send(3, mk_pw(3), 16'h3333);
        idle(5);
        chk("t6_fill10", 64'(dut.fill_q), 64'd10);
        base = rv_count;
        power = mk_pw(3); advance = 4'b0100; reset = 1'b1;
        cyc(1);
        advance = 4'b0000;
        chk("t6_result", 64'(result), 64'd0);
        chk("t6_rv", 64'(result_valid), 64'd0);
        chk("t6_overall", 64'(overall_result), 64'd0);
        chk("t6_ovalid", 64'(overall_valid), 64'd0);
        chk("t6_hit", 64'(hit), 64'd0);
        chk("t6_hit_bin", 64'(hit_bin), 64'd0);
        chk("t6_fill", 64'(dut.fill_q), 64'd0);
        chk("t6_state", 64'(dut.state_q), 64'd0);
        cyc(1);
        reset = 1'b0;
        idle(5);
        chk("t6_no_strobe", 64'(rv_count - base), 64'd0);
        chk("t6_fill_after", 64'(dut.fill_q), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
